// File: rtl/smoker_pkg.sv
// smoker_pkg: mode codes and FSM encodings shared by the smoker mode controller and hood timer.
package smoker_pkg;

   localparam logic [2:0] MODE_STANDBY = 3'd0;
   localparam logic [2:0] MODE_L1      = 3'd1;
   localparam logic [2:0] MODE_L2      = 3'd2;
   localparam logic [2:0] MODE_HURR    = 3'd3;

   typedef enum logic [2:0] {
      ST_STANDBY,
      ST_MENU,
      ST_L1,
      ST_L2,
      ST_HURR,
      ST_HURR_EXIT
   } state_e;

   // Arbitrated button event, at most one per cycle
   typedef enum logic [2:0] {
      BTN_NONE,
      BTN_MODE1,
      BTN_MODE2,
      BTN_MODE3,
      BTN_MENU
   } btn_e;

   function automatic logic [2:0] mode_of(state_e s);
      case (s)
         ST_L1:        mode_of = MODE_L1;
         ST_L2:        mode_of = MODE_L2;
         ST_HURR,
         ST_HURR_EXIT: mode_of = MODE_HURR;
         default:      mode_of = MODE_STANDBY;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, N-sample debouncer and one-cycle rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;
   logic          w_accept;

   assign w_accept = (r_s2 != r_level) && (r_cnt == CW'(DEBOUNCE_CYC - 1));
   assign o_pulse  = r_pulse;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_pulse <= w_accept & r_s2;
         if (r_s2 == r_level || w_accept)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         if (w_accept)
            r_level <= r_s2;
      end
   end

endmodule

// File: rtl/smoker_mode_ctrl.sv
// smoker_mode_ctrl: range-hood front-panel mode FSM with menu gating and one-shot hurricane.
import smoker_pkg::*;

module smoker_mode_ctrl #(
   parameter int CLK_HZ         = 500,
   parameter int DEBOUNCE_CYC   = 10,
   parameter int HURRICANE_SEC  = 60,
   parameter int EXIT_DELAY_SEC = 60
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_menu_btn,
   input  logic       i_mode1_btn,
   input  logic       i_mode2_btn,
   input  logic       i_mode3_btn,
   output logic [2:0] o_mode_state,
   output logic       o_menu_armed,
   output logic       o_hurricane_active,
   output logic       o_hurricane_used,
   output logic [6:0] o_remain_sec
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [3:0]    w_raw;
   logic [3:0]    w_pulse;
   btn_e          w_btn;
   logic          w_tick;
   logic          w_zero;
   state_e        w_nxt;
   logic [6:0]    w_rem;

   state_e        r_state;
   logic [PW-1:0] r_pre;
   logic [2:0]    r_mode;
   logic          r_armed;
   logic          r_active;
   logic          r_used;
   logic [6:0]    r_remain;

   assign w_raw = {i_mode3_btn, i_mode2_btn, i_mode1_btn, i_menu_btn};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .i_btn  (w_raw[g]),
         .o_pulse(w_pulse[g])
      );
   end

   assign w_btn  = w_pulse[0] ? BTN_MENU  :
                   w_pulse[3] ? BTN_MODE3 :
                   w_pulse[2] ? BTN_MODE2 :
                   w_pulse[1] ? BTN_MODE1 : BTN_NONE;
   assign w_tick = r_pre == PW'(CLK_HZ - 1);

   always_comb begin
      w_nxt  = r_state;
      w_rem  = r_remain;
      w_zero = 1'b0;
      case (r_state)
         ST_STANDBY:
            if (w_btn == BTN_MENU) w_nxt = ST_MENU;
         ST_MENU:
            if (w_btn == BTN_MENU) w_nxt = ST_STANDBY;
            else if (w_btn == BTN_MODE3 && !r_used) begin
               w_nxt  = ST_HURR;
               w_rem  = 7'(HURRICANE_SEC);
               w_zero = 1'b1;
            end
            else if (w_btn == BTN_MODE2) w_nxt = ST_L2;
            else if (w_btn == BTN_MODE1) w_nxt = ST_L1;
         ST_L1:
            if (w_btn == BTN_MENU) w_nxt = ST_STANDBY;
            else if (w_btn == BTN_MODE2) w_nxt = ST_L2;
         ST_L2:
            if (w_btn == BTN_MENU) w_nxt = ST_STANDBY;
            else if (w_btn == BTN_MODE1) w_nxt = ST_L1;
         ST_HURR:
            if (w_btn == BTN_MENU) begin
               w_nxt  = ST_HURR_EXIT;
               w_rem  = 7'(EXIT_DELAY_SEC);
               w_zero = 1'b1;
            end
            else if (w_tick) begin
               w_rem = (r_remain > 7'd1) ? r_remain - 7'd1 : 7'd0;
               w_nxt = (r_remain > 7'd1) ? ST_HURR : ST_L2;
            end
         ST_HURR_EXIT:
            if (w_tick) begin
               w_rem = (r_remain > 7'd1) ? r_remain - 7'd1 : 7'd0;
               w_nxt = (r_remain > 7'd1) ? ST_HURR_EXIT : ST_STANDBY;
            end
         default: begin
            w_nxt = ST_STANDBY;
            w_rem = 7'd0;
         end
      endcase
   end

   // Prescaler restarts on hurricane/exit entry so the first decrement lands CLK_HZ cycles later
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_STANDBY;
         r_pre    <= '0;
         r_mode   <= MODE_STANDBY;
         r_armed  <= 1'b0;
         r_active <= 1'b0;
         r_used   <= 1'b0;
         r_remain <= 7'd0;
      end else begin
         r_state  <= w_nxt;
         r_pre    <= (w_zero || w_tick) ? '0 : r_pre + 1'b1;
         r_mode   <= mode_of(w_nxt);
         r_armed  <= w_nxt == ST_MENU;
         r_active <= w_nxt == ST_HURR || w_nxt == ST_HURR_EXIT;
         r_used   <= r_used || w_nxt == ST_HURR;
         r_remain <= w_rem;
      end
   end

   assign o_mode_state       = r_mode;
   assign o_menu_armed       = r_armed;
   assign o_hurricane_active = r_active;
   assign o_hurricane_used   = r_used;
   assign o_remain_sec       = r_remain;

endmodule

// File: tb/tb_smoker_mode_ctrl.sv
// tb_smoker_mode_ctrl: directed panel scenarios plus random button traffic against a behavioural model.
module tb_smoker_mode_ctrl;

   localparam int CLK_HZ = 4;
   localparam int DB     = 2;
   localparam int HS     = 3;
   localparam int ES     = 2;

   localparam int S_OFF  = 0;
   localparam int S_MENU = 1;
   localparam int S_ONE  = 2;
   localparam int S_TWO  = 3;
   localparam int S_HUR  = 4;
   localparam int S_EXIT = 5;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       b_menu = 1'b0;
   logic       b1     = 1'b0;
   logic       b2     = 1'b0;
   logic       b3     = 1'b0;
   logic [2:0] mode;
   logic       armed;
   logic       hact;
   logic       used;
   logic [6:0] rem;

   int n_cmp = 0;
   int n_err = 0;

   int       m_st;
   int       m_cyc;
   int       m_t0;
   int       m_len;
   bit       m_used;
   bit [3:0] m_lvl;
   bit [3:0] m_pul;
   bit [3:0] hist[$];

   smoker_mode_ctrl #(
      .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DB), .HURRICANE_SEC(HS), .EXIT_DELAY_SEC(ES)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_menu_btn(b_menu), .i_mode1_btn(b1), .i_mode2_btn(b2), .i_mode3_btn(b3),
      .o_mode_state(mode), .o_menu_armed(armed), .o_hurricane_active(hact),
      .o_hurricane_used(used), .o_remain_sec(rem)
   );

   initial forever #5 clk = ~clk;

   task automatic check(string tag, int obs, int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Seconds left = programmed length minus whole seconds elapsed since (re)load
   function automatic int m_rem();
      return (m_st == S_HUR || m_st == S_EXIT) ? m_len - (m_cyc - m_t0) / CLK_HZ : 0;
   endfunction

   function automatic int m_mode();
      return (m_st == S_ONE) ? 1 : (m_st == S_TWO) ? 2 : (m_st >= S_HUR) ? 3 : 0;
   endfunction

   task automatic model_step();
      bit [3:0] pins;
      int       sel;
      bit       acc;
      pins = {b3, b2, b1, b_menu};
      if (!rst_n) begin
         m_st = S_OFF; m_used = 0; m_lvl = '0; m_pul = '0; m_cyc = 0; m_t0 = 0; m_len = 0;
         hist.delete();
         for (int i = 0; i < DB + 2; i++) hist.push_back(4'b0);
         return;
      end
      m_cyc++;
      sel = m_pul[0] ? 0 : m_pul[3] ? 3 : m_pul[2] ? 2 : m_pul[1] ? 1 : -1;
      case (m_st)
         S_OFF:  if (sel == 0) m_st = S_MENU;
         S_MENU: begin
            if (sel == 0) m_st = S_OFF;
            else if (sel == 3 && !m_used) begin m_st = S_HUR; m_t0 = m_cyc; m_len = HS; m_used = 1; end
            else if (sel == 2) m_st = S_TWO;
            else if (sel == 1) m_st = S_ONE;
         end
         S_ONE:  if (sel == 0) m_st = S_OFF; else if (sel == 2) m_st = S_TWO;
         S_TWO:  if (sel == 0) m_st = S_OFF; else if (sel == 1) m_st = S_ONE;
         S_HUR: begin
            if (sel == 0) begin m_st = S_EXIT; m_t0 = m_cyc; m_len = ES; end
            else if (m_rem() == 0) m_st = S_TWO;
         end
         S_EXIT: if (m_rem() == 0) m_st = S_OFF;
         default: m_st = S_OFF;
      endcase
      // A level is accepted once the last DB synchronised samples all disagree with it
      hist.push_back(pins);
      if (hist.size() > DB + 3) void'(hist.pop_front());
      for (int b = 0; b < 4; b++) begin
         acc = 1;
         for (int j = 0; j < DB; j++)
            if (hist[hist.size() - 3 - j][b] == m_lvl[b]) acc = 0;
         m_pul[b] = acc & ~m_lvl[b];
         if (acc) m_lvl[b] = ~m_lvl[b];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("mode_state", int'(mode), m_mode());
      check("menu_armed", int'(armed), int'(m_st == S_MENU));
      check("hurr_active", int'(hact), int'(m_st == S_HUR || m_st == S_EXIT));
      check("hurr_used", int'(used), int'(m_used));
      check("remain_sec", int'(rem), m_rem());
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic set_btn(int idx, logic v);
      case (idx)
         0: b_menu = v;
         1: b1 = v;
         2: b2 = v;
         default: b3 = v;
      endcase
   endtask

   task automatic press(int idx);
      set_btn(idx, 1'b1);
      run(6);
      set_btn(idx, 1'b0);
      run(5);
   endtask

   initial begin
      @(negedge clk);
      rst_n = 1'b0;
      run(2);
      check("rst_mode", int'(mode), 0);
      check("rst_remain", int'(rem), 0);
      rst_n = 1'b1;
      run(2);
      press(1);
      check("no_menu_mode1", int'(mode), 0);
      press(0);
      check("menu_armed", int'(armed), 1);
      press(1);
      check("l1_mode", int'(mode), 1);
      check("l1_disarmed", int'(armed), 0);
      press(2);
      check("l2_mode", int'(mode), 2);
      press(0);
      check("standby_mode", int'(mode), 0);
      b_menu = 1'b1;
      run(1);
      b_menu = 1'b0;
      run(6);
      check("glitch_armed", int'(armed), 0);
      press(0);
      press(3);
      check("hurr_mode", int'(mode), 3);
      check("hurr_used", int'(used), 1);
      run(20);
      check("hurr_drop_mode", int'(mode), 2);
      check("hurr_drop_remain", int'(rem), 0);
      press(0);
      press(0);
      press(3);
      check("hurr_reuse_mode", int'(mode), 0);
      check("hurr_reuse_armed", int'(armed), 1);
      rst_n = 1'b0;
      run(1);
      rst_n = 1'b1;
      check("rst_clears_used", int'(used), 0);
      press(0);
      press(3);
      check("hurr_again", int'(mode), 3);
      press(0);
      press(1);
      run(10);
      check("exit_standby", int'(mode), 0);
      press(0);
      b_menu = 1'b1;
      b1 = 1'b1;
      run(6);
      b_menu = 1'b0;
      b1 = 1'b0;
      run(5);
      check("menu_wins_mode", int'(mode), 0);
      check("menu_wins_armed", int'(armed), 0);
      rst_n = 1'b0;
      run(1);
      rst_n = 1'b1;
      press(0);
      press(3);
      #2 rst_n = 1'b0;
      #1;
      check("async_mode", int'(mode), 0);
      check("async_active", int'(hact), 0);
      check("async_used", int'(used), 0);
      check("async_remain", int'(rem), 0);
      run(2);
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) set_btn(b, ($urandom_range(0, 1) == 1));
         rst_n = ($urandom_range(0, 599) != 0);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
